// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_muldiv execute-stage ALU.
// The mul/div opcodes only do real work when ALU_MULDIV_EN is defined.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 5'h00,
    OP_ADD   = 5'h01,
    OP_SUB   = 5'h02,
    OP_AND   = 5'h03,
    OP_OR    = 5'h04,
    OP_XOR   = 5'h05,
    OP_NOR   = 5'h06,
    OP_SLT   = 5'h07,
    OP_SLL   = 5'h08,
    OP_SRL   = 5'h09,
    OP_SRA   = 5'h0A,
    OP_MULT  = 5'h0B,
    OP_MULTU = 5'h0C,
    OP_DIV   = 5'h0D,
    OP_DIVU  = 5'h0E,
    OP_MFHI  = 5'h0F,
    OP_MFLO  = 5'h10
  } op_t;

  typedef enum logic [1:0] {
    FW_NONE = 2'b00,
    FW_MEM  = 2'b10,
    FW_WB   = 2'b01
  } fw_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FIX  = 2'b10
  } state_t;

  function automatic logic is_muldiv(input op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// EX-stage request/response bundle for alu_muldiv; master = pipeline, slave = ALU.
interface alu_muldiv_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  op_t              op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [WIDTH-1:0] imm;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fwd_m;
  logic [WIDTH-1:0] fwd_w;
  fw_sel_t          fw_a;
  fw_sel_t          fw_b;
  logic             alu_src;
  logic             alu_src_shift;
  logic             reg_dst;
  logic [4:0]       rt_addr;
  logic [4:0]       rd_addr;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] write_data;
  logic [4:0]       write_reg_addr;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, flush, op, rs, rt, imm, shamt, fwd_m, fwd_w, fw_a, fw_b,
           alu_src, alu_src_shift, reg_dst, rt_addr, rd_addr,
    input  in_ready, out_valid, result, write_data, write_reg_addr, div_by_zero, busy
  );

  modport slave (
    input  in_valid, flush, op, rs, rt, imm, shamt, fwd_m, fwd_w, fw_a, fw_b,
           alu_src, alu_src_shift, reg_dst, rt_addr, rd_addr,
    output in_ready, out_valid, result, write_data, write_reg_addr, div_by_zero, busy
  );
endinterface

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on operand magnitudes with a
// final sign fix-up state. Only compiled when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             flush_i,
  input  op_t              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output state_t           state_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, mag_b_q, mag_b_d, a_q, a_d;
  logic             div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, zero_q, zero_d;
  logic             sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum, shifted, trial;
  logic [2*WIDTH-1:0] prod;

  assign sgn     = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign mag_a   = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b   = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;
  // {acc, sh} acts as the product register (mult) or remainder:quotient pair (div).
  assign sum     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mag_b_q} : '0);
  assign shifted = {acc_q, sh_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, mag_b_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    mag_b_d   = mag_b_q;
    a_d       = a_q;
    div_d     = div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d   = BUSY;
        cnt_d     = '0;
        acc_d     = '0;
        sh_d      = mag_a;
        mag_b_d   = mag_b;
        a_d       = a_i;
        div_d     = (op_i == OP_DIV) || (op_i == OP_DIVU);
        neg_d     = sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        neg_rem_d = sgn && a_i[WIDTH-1];
        zero_d    = (b_i == '0);
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          if (div_q) begin
            if (!trial[WIDTH]) begin
              acc_d = trial[WIDTH-1:0];
              sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = shifted[WIDTH-1:0];
              sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = sum[WIDTH:1];
            sh_d  = {sum[0], sh_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod = {acc_q, sh_q};
    if (neg_q) prod = -prod;
    hi_o = prod[2*WIDTH-1:WIDTH];
    lo_o = prod[WIDTH-1:0];
    if (div_q) begin
      lo_o = neg_q ? -sh_q : sh_q;
      hi_o = neg_rem_q ? -acc_q : acc_q;
      if (zero_q) begin
        lo_o = '1;
        hi_o = a_q;
      end
    end
  end

  assign state_o = state_q;
  assign done_o  = (state_q == FIX) && !flush_i;
  assign dbz_o   = div_q && zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      mag_b_q   <= '0;
      a_q       <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      mag_b_q   <= mag_b_d;
      a_q       <= a_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
    end
  end
endmodule
`endif

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: operand forwarding, destination select and registered outputs.
// Define ALU_MULDIV_EN to build the iterative MULT/DIV unit with HI/LO registers.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst_n,
  alu_muldiv_if.slave bus
);
  logic [WIDTH-1:0] a_fwd, b_fwd, op_a, op_b, alu_res;
  logic [WIDTH-1:0] result_q, result_d, wd_q, wd_d;
  logic [4:0]       wa_q, wa_d;
  logic             out_valid_q, out_valid_d;
  logic             fire;

`ifdef ALU_MULDIV_EN
  state_t           md_state;
  logic             md_done, md_dbz, dbz_q, dbz_d;
  logic [WIDTH-1:0] md_hi, md_lo, hi_q, hi_d, lo_q, lo_d;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (fire && is_muldiv(bus.op)),
    .flush_i (bus.flush),
    .op_i    (bus.op),
    .a_i     (op_a),
    .b_i     (op_b),
    .state_o (md_state),
    .done_o  (md_done),
    .dbz_o   (md_dbz),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  assign bus.in_ready    = (md_state == IDLE);
  assign bus.busy        = (md_state != IDLE);
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.in_ready    = 1'b1;
  assign bus.busy        = 1'b0;
  assign bus.div_by_zero = 1'b0;
`endif

  // flush wins over a same-cycle accept
  assign fire = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    case (bus.fw_a)
      FW_MEM:  a_fwd = bus.fwd_m;
      FW_WB:   a_fwd = bus.fwd_w;
      default: a_fwd = bus.rs;
    endcase
    case (bus.fw_b)
      FW_MEM:  b_fwd = bus.fwd_m;
      FW_WB:   b_fwd = bus.fwd_w;
      default: b_fwd = bus.rt;
    endcase
  end

  assign op_a = bus.alu_src_shift ? WIDTH'(bus.shamt) : a_fwd;
  assign op_b = bus.alu_src ? bus.imm : b_fwd;

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
      OP_SLL:  alu_res = op_b << op_a[SHW-1:0];
      OP_SRL:  alu_res = op_b >> op_a[SHW-1:0];
      OP_SRA:  alu_res = $unsigned($signed(op_b) >>> op_a[SHW-1:0]);
`ifdef ALU_MULDIV_EN
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    wd_d        = wd_q;
    wa_d        = wa_q;
`ifdef ALU_MULDIV_EN
    hi_d        = hi_q;
    lo_d        = lo_q;
    dbz_d       = dbz_q;
`endif
    if (fire) begin
      wd_d = b_fwd;
      wa_d = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
`ifdef ALU_MULDIV_EN
      if (!is_muldiv(bus.op)) begin
        out_valid_d = 1'b1;
        result_d    = alu_res;
        dbz_d       = 1'b0;
      end
`else
      out_valid_d = 1'b1;
      result_d    = alu_res;
`endif
    end
`ifdef ALU_MULDIV_EN
    if (md_done) begin
      out_valid_d = 1'b1;
      result_d    = md_lo;
      hi_d        = md_hi;
      lo_d        = md_lo;
      dbz_d       = md_dbz;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      wd_q        <= '0;
      wa_q        <= '0;
`ifdef ALU_MULDIV_EN
      hi_q        <= '0;
      lo_q        <= '0;
      dbz_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      wd_q        <= wd_d;
      wa_q        <= wa_d;
`ifdef ALU_MULDIV_EN
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.result         = result_q;
  assign bus.write_data     = wd_q;
  assign bus.write_reg_addr = wa_q;
endmodule
